keypad_matrix_scanner: RTL and testbench



---
 rtl/keypad_matrix_scanner.sv | 159 +++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x3 membrane keypad scanner: rotates an active-low column drive, assembles one
// frame per full rotation, debounces single-key frames and emits a one-hot key code.
//
// state    | meaning
// IDLE     | no key accepted, waiting for a single-key frame
// DEBOUNCE | same single key seen in consecutive frames, counting towards accept
// PRESSED  | key accepted and held; chords and rollover ignored
// RELEASE  | empty frames seen, counting towards release
module keypad_matrix_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [2:0]  col_out,
  output logic [11:0] key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state;
  logic [3:0]    row_s1, row_s2;
  logic [3:0]    pressed;
  logic [SW-1:0] slot;
  logic [1:0]    col_idx;
  logic [11:0]   acc;
  logic [11:0]   frame_mat, frame_code;
  logic [11:0]   cand;
  logic [CW-1:0] cnt, cnt_inc;
  logic          slot_end, frame_end, frame_none, frame_one;

  assign pressed   = ~row_s2;
  assign slot_end  = (slot == SLOT_LAST);
  assign frame_end = slot_end && (col_idx == 2'd2);
  assign cnt_inc   = cnt + CW'(1);

  // The column-2 sample is merged combinationally so the frame can be judged on the same edge.
  always_comb begin
    frame_mat = acc;
    for (int r = 0; r < 4; r++)
      frame_mat[r*3+2] = acc[r*3+2] | pressed[r];
  end

  // Matrix position -> key bit: r0..r2 hold digits 1..9, r3 holds '*', '0', '#'.
  assign frame_code = {frame_mat[11], frame_mat[9], frame_mat[8:0], frame_mat[10]};
  assign frame_none = (frame_code == 12'd0);
  assign frame_one  = !frame_none && ((frame_code & (frame_code - 12'd1)) == 12'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      slot    <= '0;
      col_idx <= 2'd0;
      col_out <= 3'b110;
      acc     <= 12'd0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      if (slot_end) begin
        slot    <= '0;
        col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        col_out <= {col_out[1:0], col_out[2]};
        if (frame_end)
          acc <= 12'd0;
        else
          for (int r = 0; r < 4; r++)
            acc[r*3+int'(col_idx)] <= pressed[r];
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 12'd0;
      cnt       <= '0;
      key_code  <= 12'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_one) begin
              cand <= frame_code;
              cnt  <= CW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state     <= PRESSED;
                key_code  <= frame_code;
                key_held  <= 1'b1;
                key_valid <= 1'b1;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (frame_one && frame_code == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_DONE) begin
                state     <= PRESSED;
                key_code  <= cand;
                key_held  <= 1'b1;
                key_valid <= 1'b1;
              end
            end else if (frame_one) begin
              cand <= frame_code;
              cnt  <= CW'(1);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (frame_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state    <= IDLE;
                cnt      <= '0;
                key_code <= 12'd0;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= CW'(1);
              end
            end
          end
          RELEASE: begin
            if (frame_none) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_DONE) begin
                state    <= IDLE;
                cnt      <= '0;
                key_code <= 12'd0;
                key_held <= 1'b0;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: directed keypad scenarios plus random presses,
// every cycle compared against a frame-level model of the scan and debounce rules.
module tb_keypad_matrix_scanner;
  localparam int SD = 4;
  localparam int DS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [2:0]  col_out;
  logic [11:0] key_code;
  logic        key_valid, key_held;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [11:0] keys = 12'd0;   // pressed keys, indexed by key_code bit
  logic [11:0] mat;            // same keys as matrix positions row*3+col

  always #5 clk = ~clk;

  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  function automatic int key_pos(input int k);
    if (k >= 1 && k <= 9) return k - 1;
    if (k == 0) return 10;
    if (k == 10) return 9;
    return 11;
  endfunction

  function automatic logic [11:0] keys_to_mat(input logic [11:0] ks);
    logic [11:0] m = 12'd0;
    for (int k = 0; k < 12; k++) if (ks[k]) m[key_pos(k)] = 1'b1;
    return m;
  endfunction

  function automatic logic [11:0] mat_to_code(input logic [11:0] m);
    logic [11:0] c = 12'd0;
    for (int k = 0; k < 12; k++) c[k] = m[key_pos(k)];
    return c;
  endfunction

  // Physical matrix: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    mat = keys_to_mat(keys);
    for (int r = 0; r < 4; r++) begin
      row_in[r] = 1'b1;
      for (int c = 0; c < 3; c++)
        if (mat[r*3+c] && col_out[c] === 1'b0) row_in[r] = 1'b0;
    end
  end

  // Reference model state
  int          e, phase, cnt, m_pulses;
  logic [11:0] p1, p2, facc, cand, m_code;
  logic        m_held, m_valid;
  logic [2:0]  m_col;

  task automatic accept();
    phase = 2; m_code = cand; m_held = 1'b1; m_valid = 1'b1; m_pulses++;
  endtask

  task automatic release_done();
    phase = 0; cnt = 0; m_code = 12'd0; m_held = 1'b0;
  endtask

  task automatic do_frame(input logic [11:0] code);
    int n = $countones(code);
    case (phase)
      0: if (n == 1) begin
           cand = code; cnt = 1;
           if (cnt >= DS) accept(); else phase = 1;
         end
      1: if (n == 1 && code == cand) begin
           cnt++;
           if (cnt >= DS) accept();
         end else if (n == 1) begin
           cand = code; cnt = 1;
         end else begin
           phase = 0; cnt = 0;
         end
      2: if (n == 0) begin
           cnt = 1;
           if (cnt >= DS) release_done(); else phase = 3;
         end
      default: if (n == 0) begin
           cnt++;
           if (cnt >= DS) release_done();
         end else begin
           phase = 2; cnt = 0;
         end
    endcase
  endtask

  // One clock edge of the model; e counts edges since reset was released.
  task automatic model_edge();
    int slot, c, idx;
    if (rst) begin
      e = 0; p1 = 0; p2 = 0; facc = 0; phase = 0; cnt = 0; cand = 0;
      m_code = 0; m_held = 0; m_valid = 0; m_col = 3'b110;
    end else begin
      m_valid = 1'b0;
      slot = e % SD;
      c = (e / SD) % 3;
      if (slot == SD - 1) begin
        // synchronizer: the sampled rows are those present two edges earlier
        for (int r = 0; r < 4; r++) facc[r*3+c] = p2[r*3+c];
        if (c == 2) begin
          do_frame(mat_to_code(facc));
          facc = 12'd0;
        end
      end
      idx = ((e + 1) / SD) % 3;
      m_col = 3'b111 ^ (3'b001 << idx);
      p2 = p1;
      p1 = mat;
      e++;
    end
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      if (key_valid === 1'b1) pulses++;
      check("col_out", 12'(col_out), 12'(m_col));
      check("key_code", key_code, m_code);
      check("key_valid", 12'(key_valid), 12'(m_valid));
      check("key_held", 12'(key_held), 12'(m_held));
    end
  endtask

  task automatic align();
    step((3*SD - (e % (3*SD))) % (3*SD));
  endtask

  initial begin
    e = 0; m_pulses = 0;
    // reset state and column rotation
    rst = 1'b1; keys = 12'd0;
    step(3);
    check("rst_col", 12'(col_out), 12'h006);
    check("rst_code", key_code, 12'h000);
    check("rst_valid", 12'(key_valid), 12'h0);
    check("rst_held", 12'(key_held), 12'h0);
    rst = 1'b0;
    step(4); check("rot_101", 12'(col_out), 12'h005);
    step(4); check("rot_011", 12'(col_out), 12'h003);
    step(4); check("rot_110", 12'(col_out), 12'h006);

    // clean press of '5'
    pulses = 0; keys = 12'h020; step(60);
    check("p5_pulses", 12'(pulses), 12'd1);
    check("p5_code", key_code, 12'h020);
    check("p5_held", 12'(key_held), 12'h1);
    keys = 12'h000; step(36);
    check("p5_rel_code", key_code, 12'h000);
    check("p5_rel_held", 12'(key_held), 12'h0);
    align();

    // '#' bouncing every 5 cycles, then stable
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 12'h000 : 12'h800;
      step(5);
    end
    check("bnc_nopulse", 12'(pulses), 12'd0);
    keys = 12'h800; step(48);
    check("bnc_pulses", 12'(pulses), 12'd1);
    check("bnc_code", key_code, 12'h800);
    keys = 12'h000; step(36); align();

    // chord '1'+'2', then '1' lifted
    pulses = 0; keys = 12'h006; step(60);
    check("chord_nopulse", 12'(pulses), 12'd0);
    check("chord_code", key_code, 12'h000);
    keys = 12'h004; step(48);
    check("chord_pulses", 12'(pulses), 12'd1);
    check("chord_code2", key_code, 12'h004);
    keys = 12'h000; step(36); align();

    // '*' with a one-frame open during the hold
    pulses = 0; keys = 12'h400; step(48);
    keys = 12'h000; step(12);
    keys = 12'h400; step(36);
    check("roll_pulses", 12'(pulses), 12'd1);
    check("roll_held", 12'(key_held), 12'h1);
    check("roll_code", key_code, 12'h400);
    keys = 12'h000; step(36); align();

    // reset while '9' is held and accepted
    pulses = 0; keys = 12'h200; step(48);
    check("r9_code", key_code, 12'h200);
    check("r9_pulses", 12'(pulses), 12'd1);
    rst = 1'b1; step(3);
    check("r9_rst_code", key_code, 12'h000);
    check("r9_rst_held", 12'(key_held), 12'h0);
    check("r9_rst_col", 12'(col_out), 12'h006);
    rst = 1'b0; pulses = 0; step(60);
    check("r9_again_pulses", 12'(pulses), 12'd1);
    check("r9_again_code", key_code, 12'h200);
    keys = 12'h000; step(36);

    // random presses, chords, gaps and occasional resets
    pulses = 0; m_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 9);
      if (kind < 2)
        keys = 12'h000;
      else if (kind < 4)
        keys = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
      else
        keys = 12'h001 << $urandom_range(0, 11);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0;
      end
      step($urandom_range(1, 60));
    end
    keys = 12'h000; step(40);
    check("rand_pulses", 12'(pulses), 12'(m_pulses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
